// File: rtl/mem_resp_unit.sv
// mem_resp_unit: in-order data-memory responder behind the load-store queue.
// Issued requests are queued in a small FIFO. Each one is then served by a
// single-outstanding FSM against a private word-addressed memory.
module mem_resp_unit #(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 256,
    parameter int LAT       = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_store,
    input  logic        req_fwd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_pc,
    output logic [31:0] resp_data,
    output logic        resp_store,
    output logic        resp_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_data  [DEPTH];
    logic [IW-1:0] fifo_idx   [DEPTH];
    logic          fifo_mis   [DEPTH];
    logic          fifo_store [DEPTH];
    logic          fifo_fwd   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    logic [31:0]   mem [MEM_WORDS];
    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [IW-1:0] acc_idx;
    logic [31:0]   acc_data;
    logic          mem_we;
    logic          unused_addr_hi;

    // Address bits above the word index are deliberately ignored, so the memory aliases.
    assign unused_addr_hi = ^req_addr[31:IW+2];

    assign req_ready  = (count != FULL_CNT);
    assign push       = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    // FIFO payload storage. Alignment and forwarding are decoded once, on entry.
    // A forward flag on a store is dropped here, so that store is handled normally.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_data[wr_ptr]  <= req_data;
            fifo_idx[wr_ptr]   <= req_addr[IW+1:2];
            fifo_mis[wr_ptr]   <= (req_addr[1:0] != 2'b00);
            fifo_store[wr_ptr] <= req_store;
            fifo_fwd[wr_ptr]   <= req_fwd && !req_store;
        end
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // Next state, pop, and the memory write strobe for the last access cycle.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        mem_we  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (fifo_mis[rd_ptr] || fifo_fwd[rd_ptr]) state_n = RESP;
                    else                                      state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_n = RESP;
                    mem_we  = resp_store;
                end
            end
            RESP: begin
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Access registers and response fields. Loaded on pop; load data is captured on the last access cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt        <= '0;
            acc_idx    <= '0;
            acc_data   <= '0;
            resp_pc    <= '0;
            resp_data  <= '0;
            resp_store <= 1'b0;
            resp_err   <= 1'b0;
        end else if (pop) begin
            resp_pc    <= fifo_pc[rd_ptr];
            resp_store <= fifo_store[rd_ptr];
            resp_err   <= fifo_mis[rd_ptr];
            resp_data  <= (!fifo_mis[rd_ptr] && fifo_fwd[rd_ptr]) ? fifo_data[rd_ptr] : '0;
            acc_idx    <= fifo_idx[rd_ptr];
            acc_data   <= fifo_data[rd_ptr];
            cnt        <= CNT_INIT;
        end else if (state == ACCESS) begin
            if (cnt != '0)        cnt       <= cnt - 1'b1;
            else if (!resp_store) resp_data <= mem[acc_idx];
        end
    end

    // Data memory. Reset clears every word, and it also blocks any write that is still in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[acc_idx] <= acc_data;
        end
    end
endmodule

// File: tb/tb_mem_resp_unit.sv
// tb_mem_resp_unit: scoreboard bench for mem_resp_unit.
// An expected response is queued when a request is accepted. It is compared when the DUT responds.
module tb_mem_resp_unit;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 256;
    localparam int LAT       = 2;
    localparam int IW        = $clog2(MEM_WORDS);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        store;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_pc = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        req_store = 1'b0;
    logic        req_fwd = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_pc;
    logic [31:0] resp_data;
    logic        resp_store;
    logic        resp_err;

    resp_t       exp_q[$];
    logic [31:0] model_mem [MEM_WORDS];
    int          passed = 0;
    int          total  = 0;

    mem_resp_unit #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS), .LAT(LAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_store  (req_store),
        .req_fwd    (req_fwd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_pc    (resp_pc),
        .resp_data  (resp_data),
        .resp_store (resp_store),
        .resp_err   (resp_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Safety net so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1, "[TB] watchdog");
    end

    function automatic string fmt(input resp_t r);
        return $sformatf("pc=%h data=%h store=%b err=%b", r.pc, r.data, r.store, r.err);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;
        exp_q.delete();
    endtask

    // Called at a negedge: present one request for one cycle. Queue its expected response if accepted.
    task automatic drive_req(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data,
                             input logic store, input logic fwd, output bit accepted);
        resp_t         e;
        logic [IW-1:0] idx;
        req_pc    = pc;
        req_addr  = addr;
        req_data  = data;
        req_store = store;
        req_fwd   = fwd;
        req_valid = 1'b1;
        accepted  = req_ready;
        if (accepted) begin
            idx     = addr[IW+1:2];
            e.pc    = pc;
            e.store = store;
            e.err   = (addr[1:0] != 2'b00);
            e.data  = '0;
            if (!e.err) begin
                if (store)    model_mem[idx] = data;
                else if (fwd) e.data = data;
                else          e.data = model_mem[idx];
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_store = 1'b0;
        req_fwd   = 1'b0;
    endtask

    // Wait (bounded) for resp_valid, capture the response and consume the handshake if ready is high
    task automatic collect(input int budget, output bit got, output int cyc, output resp_t act);
        cyc = 0;
        while (!resp_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        got = resp_valid;
        act = {resp_pc, resp_data, resp_store, resp_err};
        if (got && resp_ready) @(negedge clk);
    endtask

    task automatic test_reset();
        bit    acc, got;
        int    cyc;
        resp_t act, e;
        @(negedge clk);
        rstn = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        clear_model();
        total++;
        if ({resp_valid, req_ready, resp_pc, resp_data, resp_store, resp_err} !== {1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0})
            $display("[TB] FAIL reset_state: valid=%b ready=%b pc=%h data=%h store=%b err=%b, expected 0 1 0 0 0 0",
                     resp_valid, req_ready, resp_pc, resp_data, resp_store, resp_err);
        else passed++;
        drive_req(32'h0, 32'h40, 32'h0, 1'b0, 1'b0, acc);
        collect(20, got, cyc, act);
        total++;
        if (!got) $display("[TB] FAIL reset_load: no response within budget");
        else if (exp_q.size() == 0) $display("[TB] FAIL reset_load: unexpected response %s", fmt(act));
        else begin
            e = exp_q.pop_front();
            if (act !== e) $display("[TB] FAIL reset_load: got %s expected %s", fmt(act), fmt(e));
            else passed++;
        end
    endtask

    task automatic test_store_load();
        bit    acc, got;
        int    cyc;
        resp_t act, e;
        drive_req(32'h4, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0, acc);
        drive_req(32'h8, 32'h40, 32'h0, 1'b0, 1'b0, acc);
        collect(20, got, cyc, act);
        total++;
        if (!got) $display("[TB] FAIL store_resp: no response within budget");
        else if (exp_q.size() == 0) $display("[TB] FAIL store_resp: unexpected response %s", fmt(act));
        else begin
            e = exp_q.pop_front();
            if (act !== e) $display("[TB] FAIL store_resp: got %s expected %s", fmt(act), fmt(e));
            else passed++;
        end
        collect(20, got, cyc, act);
        total++;
        if (!got) $display("[TB] FAIL load_resp: no response within budget");
        else if (exp_q.size() == 0) $display("[TB] FAIL load_resp: unexpected response %s", fmt(act));
        else begin
            e = exp_q.pop_front();
            if (act !== e) $display("[TB] FAIL load_resp: got %s expected %s", fmt(act), fmt(e));
            else passed++;
        end
        total++;
        if (cyc != LAT + 1) $display("[TB] FAIL load_latency: %0d cycles after store handshake, expected %0d", cyc, LAT + 1);
        else passed++;
    endtask

    task automatic test_forward();
        bit    acc, got;
        int    cyc;
        resp_t act, e;
        drive_req(32'hC, 32'h40, 32'h1234, 1'b0, 1'b1, acc);
        collect(20, got, cyc, act);
        total++;
        if (!got) $display("[TB] FAIL fwd_resp: no response within budget");
        else if (exp_q.size() == 0) $display("[TB] FAIL fwd_resp: unexpected response %s", fmt(act));
        else begin
            e = exp_q.pop_front();
            if (act !== e) $display("[TB] FAIL fwd_resp: got %s expected %s", fmt(act), fmt(e));
            else passed++;
        end
        total++;
        if (cyc != 1) $display("[TB] FAIL fwd_latency: %0d cycles after accept, expected 1", cyc);
        else passed++;
        drive_req(32'h10, 32'h40, 32'h0, 1'b0, 1'b0, acc);
        collect(20, got, cyc, act);
        total++;
        if (!got) $display("[TB] FAIL fwd_mem_unchanged: no response within budget");
        else if (exp_q.size() == 0) $display("[TB] FAIL fwd_mem_unchanged: unexpected response %s", fmt(act));
        else begin
            e = exp_q.pop_front();
            if (act !== e) $display("[TB] FAIL fwd_mem_unchanged: got %s expected %s", fmt(act), fmt(e));
            else passed++;
        end
    endtask

    task automatic test_misaligned();
        bit    acc, got;
        int    cyc;
        resp_t act, e;
        drive_req(32'h14, 32'h42, 32'hCAFEF00D, 1'b1, 1'b0, acc);
        drive_req(32'h18, 32'h40, 32'h0, 1'b0, 1'b0, acc);
        for (int k = 0; k < 2; k++) begin
            collect(20, got, cyc, act);
            total++;
            if (!got) $display("[TB] FAIL misaligned_%0d: no response within budget", k);
            else if (exp_q.size() == 0) $display("[TB] FAIL misaligned_%0d: unexpected response %s", k, fmt(act));
            else begin
                e = exp_q.pop_front();
                if (act !== e) $display("[TB] FAIL misaligned_%0d: got %s expected %s", k, fmt(act), fmt(e));
                else passed++;
            end
        end
    endtask

    task automatic test_full();
        bit    acc, got, last_acc;
        int    cyc, n_acc, seen;
        resp_t act, e;
        resp_ready = 1'b0;
        n_acc = 0;
        last_acc = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive_req(32'h100 + 32'(4 * i), 32'h40, 32'h9000 + 32'(i), 1'b0, i[0], acc);
            if (acc) n_acc++;
            last_acc = acc;
        end
        total++;
        if (n_acc != DEPTH + 1) $display("[TB] FAIL full_accept_count: accepted %0d, expected %0d", n_acc, DEPTH + 1);
        else passed++;
        total++;
        if (req_ready !== 1'b0 || last_acc !== 1'b0)
            $display("[TB] FAIL full_ready: req_ready=%b extra_accepted=%b, expected 0 0", req_ready, last_acc);
        else passed++;
        resp_ready = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            collect(20, got, cyc, act);
            total++;
            if (!got) $display("[TB] FAIL full_order_%0d: no response within budget", k);
            else if (exp_q.size() == 0) $display("[TB] FAIL full_order_%0d: unexpected response %s", k, fmt(act));
            else begin
                e = exp_q.pop_front();
                if (act !== e) $display("[TB] FAIL full_order_%0d: got %s expected %s", k, fmt(act), fmt(e));
                else passed++;
            end
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        total++;
        if (seen != 0 || exp_q.size() != 0)
            $display("[TB] FAIL full_drained: extra valid cycles=%0d pending=%0d, expected 0 0", seen, exp_q.size());
        else passed++;
    endtask

    task automatic test_alias();
        bit    acc, got;
        int    cyc;
        resp_t act, e;
        drive_req(32'h30, 32'h40 + 32'(4 * MEM_WORDS), 32'h55, 1'b1, 1'b0, acc);
        drive_req(32'h34, 32'h40, 32'h0, 1'b0, 1'b0, acc);
        for (int k = 0; k < 2; k++) begin
            collect(20, got, cyc, act);
            total++;
            if (!got) $display("[TB] FAIL alias_%0d: no response within budget", k);
            else if (exp_q.size() == 0) $display("[TB] FAIL alias_%0d: unexpected response %s", k, fmt(act));
            else begin
                e = exp_q.pop_front();
                if (act !== e) $display("[TB] FAIL alias_%0d: got %s expected %s", k, fmt(act), fmt(e));
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        bit    acc, got;
        int    cyc, seen;
        resp_t act, e;
        drive_req(32'h200, 32'h80, 32'hAAAA5555, 1'b1, 1'b0, acc);
        drive_req(32'h204, 32'h84, 32'h12345678, 1'b1, 1'b0, acc);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        clear_model();
        total++;
        if ({resp_valid, req_ready} !== 2'b01)
            $display("[TB] FAIL midreset_state: valid=%b ready=%b, expected 0 1", resp_valid, req_ready);
        else passed++;
        drive_req(32'h208, 32'h80, 32'h0, 1'b0, 1'b0, acc);
        drive_req(32'h20C, 32'h40, 32'h0, 1'b0, 1'b0, acc);
        for (int k = 0; k < 2; k++) begin
            collect(20, got, cyc, act);
            total++;
            if (!got) $display("[TB] FAIL midreset_load_%0d: no response within budget", k);
            else if (exp_q.size() == 0) $display("[TB] FAIL midreset_load_%0d: unexpected response %s", k, fmt(act));
            else begin
                e = exp_q.pop_front();
                if (act !== e) $display("[TB] FAIL midreset_load_%0d: got %s expected %s", k, fmt(act), fmt(e));
                else passed++;
            end
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        total++;
        if (seen != 0) $display("[TB] FAIL midreset_fifo_empty: %0d stray valid cycles, expected 0", seen);
        else passed++;
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_store_load();
        test_forward();
        test_misaligned();
        test_full();
        test_alias();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
